// File: rtl/led_step_counter_pkg.sv
// Shared types and constants for the LED step counter: FSM state encoding,
// default debounce window and small state decode helpers.
package led_step_counter_pkg;

    localparam int DB_CYCLES_DEFAULT = 1250000;

    // Bit 1 = paused, bit 0 = counting down.
    typedef enum logic [1:0] {
        RUN_UP     = 2'b00,
        RUN_DOWN   = 2'b01,
        PAUSE_UP   = 2'b10,
        PAUSE_DOWN = 2'b11
    } state_t;

    function automatic logic is_up(input state_t s);
        return (s == RUN_UP) || (s == PAUSE_UP);
    endfunction

    function automatic logic is_running(input state_t s);
        return (s == RUN_UP) || (s == RUN_DOWN);
    endfunction

    function automatic state_t make_state(input logic run, input logic up);
        return state_t'({~run, ~up});
    endfunction

endpackage

// File: rtl/led_step_counter_if.sv
// Board-side signal bundle of the LED step counter: raw switches/buttons,
// the divided tick, and the registered LED/status outputs.
interface led_step_counter_if #(
    parameter int WIDTH = 4
);
    logic             TickIn;
    logic             BtnMode;
    logic             BtnPause;
    logic             LoadEn;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Count;
    logic             Dir;
    logic             Running;
    logic             Wrap;

    modport master (
        output TickIn, BtnMode, BtnPause, LoadEn, LoadVal,
        input  Count, Dir, Running, Wrap
    );

    modport slave (
        input  TickIn, BtnMode, BtnPause, LoadEn, LoadVal,
        output Count, Dir, Running, Wrap
    );
endinterface

// File: rtl/led_step_counter_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-window debounce and
// a one-cycle press pulse on the debounced rising edge (release is silent).
module button_debounce
    import led_step_counter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic ClkIn,
    input  logic RstN,
    input  logic i_btn,
    output logic o_press
);

    localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, matching the hardware regardless of statement order.
    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_step_counter.sv
// LED step counter: synchronised tick drives an up/down modulo counter whose
// direction and run/pause state are toggled by debounced push-buttons.
module led_step_counter
    import led_step_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                ClkIn,
    input  logic                RstN,
    led_step_counter_if.slave   bus
);

    logic [1:0]       r_tick_sync;
    logic [1:0]       r_sync_valid;
    logic [1:0]       r_load_en_sync;
    logic [WIDTH-1:0] r_load_val_meta;
    logic [WIDTH-1:0] r_load_val_sync;
    logic             r_tick_prev;
    logic             r_tick_armed;
    logic             r_step;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    state_t           r_state;
    state_t           w_state_next;
    logic             w_step_rise;
    logic             w_mode_press;
    logic             w_pause_press;
    logic             w_dir;
    logic             w_running;

    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) begin
            r_tick_sync     <= '0;
            r_sync_valid    <= '0;
            r_load_en_sync  <= '0;
            r_load_val_meta <= '0;
            r_load_val_sync <= '0;
        end else begin
            r_tick_sync     <= {r_tick_sync[0], bus.TickIn};
            r_sync_valid    <= {r_sync_valid[0], 1'b1};
            r_load_en_sync  <= {r_load_en_sync[0], bus.LoadEn};
            r_load_val_meta <= bus.LoadVal;
            r_load_val_sync <= r_load_val_meta;
        end
    end

    // The synchroniser's reset zeros are not a real low observation, so arming
    // waits until the synchronised tick carries sampled data.
    assign w_step_rise = r_tick_sync[1] & ~r_tick_prev & r_tick_armed;

    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) begin
            r_tick_prev  <= 1'b0;
            r_tick_armed <= 1'b0;
            r_step       <= 1'b0;
        end else begin
            r_tick_prev  <= r_tick_sync[1];
            r_tick_armed <= r_tick_armed | (r_sync_valid[1] & ~r_tick_sync[1]);
            r_step       <= w_step_rise;
        end
    end

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
        .ClkIn   (ClkIn),
        .RstN    (RstN),
        .i_btn   (bus.BtnMode),
        .o_press (w_mode_press)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
        .ClkIn   (ClkIn),
        .RstN    (RstN),
        .i_btn   (bus.BtnPause),
        .o_press (w_pause_press)
    );

    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) r_state <= RUN_UP;
        else       r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a value on every path (default first)
    // so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (w_mode_press || w_pause_press)
            w_state_next = make_state(is_running(r_state) ^ w_pause_press,
                                      is_up(r_state) ^ w_mode_press);
    end

    always_comb begin
        w_dir     = is_up(r_state);
        w_running = is_running(r_state);
    end

    // Direction comes from the pre-edge state, so a simultaneous mode press
    // only affects later steps.
    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_load_en_sync[1]) begin
                r_count <= r_load_val_sync;
            end else if (r_step && w_running) begin
                if (w_dir) begin
                    r_count <= r_count + WIDTH'(1);
                    r_wrap  <= &r_count;
                end else begin
                    r_count <= r_count - WIDTH'(1);
                    r_wrap  <= ~|r_count;
                end
            end
        end
    end

    assign bus.Count   = r_count;
    assign bus.Wrap    = r_wrap;
    assign bus.Dir     = w_dir;
    assign bus.Running = w_running;

endmodule
